bitserial_addf_accum: RTL and testbench

Bit-serial adder built around the library 9T full-adder cell (addf_1). It is the sequential stage that sits directly around that cell, feeding it one operand bit pair plus a registered carry each clock. It collects the sum bits and final carry into a parallel result. Used where area matters more than throughput, for example in generator counter and offset paths: one full-adder cell plus flops replaces a WIDTH-bit ripple adder.

---
 rtl/bitserial_addf_accum.sv | 123 ++++++++++++
 tb/tb_bitserial_addf_accum.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bitserial_addf_accum.sv
// bitserial_addf_accum
// Bit-serial adder built around a single full-adder cell. Each RUN cycle it
// adds one LSB-first bit pair plus the registered carry. The result is
// collected in a shift register and published on S/CO only at completion.
module bitserial_addf_accum #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] sa_reg, sb_reg, r_reg, s_reg;
  logic             c_reg, co_reg;
  logic [CW-1:0]    cnt_reg;

  logic             fa_sum, fa_carry;
  logic             last_bit;
  logic [WIDTH-1:0] sa_shift, sb_shift, r_shift;

  // The full-adder cell: current operand LSBs plus the carry flop
  assign fa_sum   = sa_reg[0] ^ sb_reg[0] ^ c_reg;
  assign fa_carry = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & c_reg) | (sb_reg[0] & c_reg);

  assign last_bit = (cnt_reg == LAST_BIT);

  // Operands shift right with zero fill; the result shifts right with the
  // new sum bit entering at the top, so the LSB ends up at bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign sa_shift[gi] = sa_reg[gi+1];
      assign sb_shift[gi] = sb_reg[gi+1];
      assign r_shift[gi]  = r_reg[gi+1];
    end
  endgenerate

  assign sa_shift[WIDTH-1] = 1'b0;
  assign sb_shift[WIDTH-1] = 1'b0;
  assign r_shift[WIDTH-1]  = fa_sum;

  // Next-state decode; illegal encodings fall back to IDLE
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: state_next = START ? ST_RUN : ST_IDLE;
      ST_RUN:  state_next = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: capture operands on acceptance, shift while running, and
  // publish the result only on the edge that enters DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sa_reg  <= '0;
      sb_reg  <= '0;
      r_reg   <= '0;
      c_reg   <= 1'b0;
      cnt_reg <= '0;
      s_reg   <= '0;
      co_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            sa_reg  <= A;
            sb_reg  <= B;
            c_reg   <= CI;
            cnt_reg <= '0;
          end
        end
        ST_RUN: begin
          sa_reg  <= sa_shift;
          sb_reg  <= sb_shift;
          r_reg   <= r_shift;
          c_reg   <= fa_carry;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_bit) begin
            s_reg  <= r_shift;
            co_reg <= fa_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign BUSY = (state_reg == ST_RUN);
  assign DONE = (state_reg == ST_DONE);
  assign S    = s_reg;
  assign CO   = co_reg;

endmodule

// File: tb/tb_bitserial_addf_accum.sv
// Directed bench for bitserial_addf_accum: an 8-bit instance for timing,
// hold, busy-ignore and reset behaviour, and a 2-bit instance swept over
// every operand/carry combination.
module tb_bitserial_addf_accum;

  logic       CLK;
  logic       RST;

  logic       START;
  logic [7:0] A, B;
  logic       CI;
  logic       BUSY, DONE;
  logic [7:0] S;
  logic       CO;

  logic       START2;
  logic [1:0] A2, B2;
  logic       CI2;
  logic       BUSY2, DONE2;
  logic [1:0] S2;
  logic       CO2;

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [7:0] s_prev  = 8'h00;
  logic       co_prev = 1'b0;

  bitserial_addf_accum #(.WIDTH(8)) u8 (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CI(CI),
    .BUSY(BUSY), .DONE(DONE), .S(S), .CO(CO)
  );

  bitserial_addf_accum #(.WIDTH(2)) u2 (
    .CLK(CLK), .RST(RST), .START(START2), .A(A2), .B(B2), .CI(CI2),
    .BUSY(BUSY2), .DONE(DONE2), .S(S2), .CO(CO2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One complete 8-bit addition, checked cycle by cycle; optionally pokes
  // START with junk operands in the middle of RUN.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic eco,
                        input bit poke);
    A = a; B = b; CI = ci; START = 1'b1;
    step();
    START = 1'b0; A = ~a; B = ~b; CI = ~ci;
    chk({tag, " busy@k"}, 32'(BUSY), 32'd1);
    chk({tag, " done@k"}, 32'(DONE), 32'd0);
    for (int i = 1; i < 8; i++) begin
      if (poke && i == 2) begin
        START = 1'b1; A = 8'h01; B = 8'h01; CI = 1'b0;
      end
      step();
      chk({tag, " busy run"}, 32'(BUSY), 32'd1);
      chk({tag, " done run"}, 32'(DONE), 32'd0);
      chk({tag, " S held run"}, 32'({CO, S}), 32'({co_prev, s_prev}));
    end
    START = 1'b0;
    step();
    chk({tag, " done pulse"}, 32'({BUSY, DONE}), 32'b01);
    chk({tag, " result"}, 32'({CO, S}), 32'({eco, es}));
    step();
    chk({tag, " idle after"}, 32'({BUSY, DONE}), 32'b00);
    chk({tag, " result held"}, 32'({CO, S}), 32'({eco, es}));
    $display("op %s: A=%02h B=%02h CI=%0d -> S=%02h CO=%0d", tag, a, b, ci, S, CO);
    s_prev  = es;
    co_prev = eco;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0; CI = 1'b0;
    START2 = 1'b0; A2 = '0; B2 = '0; CI2 = 1'b0;
    #1;
    chk("reset outputs", 32'({BUSY, DONE, CO, S}), 32'd0);
    step();
    step();
    chk("reset held over clocks", 32'({BUSY, DONE, CO, S}), 32'd0);
    chk("reset w2", 32'({BUSY2, DONE2, CO2, S2}), 32'd0);
    RST = 1'b0;

    run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
    run_op("ripple1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0);
    run_op("ripple2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);

    // Held idle cycles keep the last result
    step();
    step();
    chk("held idle", 32'({BUSY, DONE, CO, S}), 32'({2'b00, 1'b1, 8'hFF}));

    // START held continuously: acceptances at cycles 0,10,20; DONE at 8,18,28
    A = 8'h12; B = 8'h34; CI = 1'b0; START = 1'b1;
    step();
    for (int c = 1; c < 30; c++) begin
      step();
      chk("cont done", 32'(DONE), 32'((c % 10) == 8));
      chk("cont busy", 32'(BUSY), 32'((c % 10) <= 7));
      if ((c % 10) == 8) begin
        chk("cont result", 32'({CO, S}), 32'h046);
        $display("continuous op at cycle %0d: S=%02h CO=%0d", c, S, CO);
      end
    end
    START = 1'b0;
    s_prev = 8'h46; co_prev = 1'b0;

    // START reasserted during RUN must be ignored
    run_op("busy poke", 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1);
    step();
    chk("no extra op", 32'({BUSY, DONE}), 32'b00);
    step();
    chk("no extra op2", 32'({BUSY, DONE, CO, S}), 32'({2'b00, 9'h031}));

    // Reset in the middle of an addition, checked without a clock edge
    A = 8'hC3; B = 8'h11; CI = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    step(); step(); step();
    chk("pre-reset busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    chk("async reset", 32'({BUSY, DONE, CO, S}), 32'd0);
    #2;
    RST = 1'b0;
    s_prev = 8'h00; co_prev = 1'b0;
    $display("reset mid-op: BUSY=%0d DONE=%0d S=%02h CO=%0d", BUSY, DONE, S, CO);
    run_op("after reset", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0);

    // WIDTH=2 exhaustive sweep, back to back at the minimum spacing
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      int         expv;
      v = 5'(i);
      A2 = v[4:3]; B2 = v[2:1]; CI2 = v[0]; START2 = 1'b1;
      expv = int'(v[4:3]) + int'(v[2:1]) + int'(v[0]);
      step();
      START2 = 1'b0;
      chk("w2 busy", 32'(BUSY2), 32'd1);
      step();
      step();
      chk("w2 done", 32'({BUSY2, DONE2}), 32'b01);
      chk("w2 sum", 32'({CO2, S2}), 32'(expv));
      $display("w2 A=%0d B=%0d CI=%0d -> CO=%0d S=%0d", A2, B2, CI2, CO2, S2);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
